rc4_phase_sequencer: RTL
========================

// Module: rc4_phase_sequencer
// PURPOSE
//  Top-level scheduler for the RC4 key-search datapath. Sequences the three S-memory phases (init, shuffle, decrypt) per candidate key and
//  arbitrates the single-port S RAM between them. Checks each decrypted byte and steps the key until a printable plaintext is found or keys run out.
// PARAMETERS
//  RAM_WIDTH   8        S RAM data width / plaintext byte width
//  RAM_LENGTH  8        S RAM address width
//  KEY_WIDTH   24       candidate key width
//  KEY_MAX     2**22-1  last key tried (inclusive); search range 0..KEY_MAX
// PORTS
//  clk          in   1           system clock; single clock domain
//  reset_n      in   1           asynchronous, active-low reset
//  start        in   1           level; rising edge launches a search
//  key          out  KEY_WIDTH   current candidate key; stable for a whole trial
//  init_start   out  1           1-cycle pulse: start S init phase
//  init_done    in   1           init phase complete
//  init_sAddr/init_sIn/init_sWren    in  RAM_LENGTH/RAM_WIDTH/1   init phase S port
//  shuf_start   out  1           1-cycle pulse: start shuffle phase
//  shuf_done    in   1           shuffle phase complete
//  shuf_sAddr/shuf_sIn/shuf_sWren    in  RAM_LENGTH/RAM_WIDTH/1   shuffle phase S port
//  dec_start    out  1           1-cycle pulse: start decrypt phase
//  dec_done     in   1           decrypt phase complete
//  dec_sAddr/dec_sIn/dec_sWren       in  RAM_LENGTH/RAM_WIDTH/1   decrypt phase S port
//  dec_aIn      in   RAM_WIDTH   plaintext byte being written
//  dec_aWren    in   1           plaintext write strobe
//  phase_abort  out  1           1-cycle pulse: decryptor must drop to idle
//  sAddr/sIn/sWren  out  RAM_LENGTH/RAM_WIDTH/1  arbitrated S RAM port
//  busy         out  1           search in progress
//  found        out  1           key holds a valid key
//  fail         out  1           range exhausted, no key valid
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; key=0; all *_start, phase_abort, sWren=0; sAddr=0; sIn=0; busy=found=fail=0; bad flag=0; edge reg=0.
//  Start edge: start_q registered; edge = start & ~start_q. Edges outside IDLE/FOUND/EXHAUSTED ignored.
//  FSM states / transitions (one per clk):
//   IDLE      -edge-> INIT_GO (key=0, found=fail=0, busy=1)
//   INIT_GO   init_start=1 -> INIT_RUN
//   INIT_RUN  wait init_done=1 -> SHUF_GO
//   SHUF_GO   shuf_start=1 -> SHUF_RUN
//   SHUF_RUN  wait shuf_done=1 -> DEC_GO
//   DEC_GO    dec_start=1, bad:=0 -> DEC_RUN
//   DEC_RUN   bad byte write -> phase_abort=1 -> NEXT_KEY (or EXHAUSTED if key==KEY_MAX);
//             dec_done=1 & no bad byte -> FOUND
//   NEXT_KEY  key<=key+1 -> INIT_GO
//   FOUND     busy=0, found=1, key held; -edge-> INIT_GO with key=0
//   EXHAUSTED busy=0, fail=1, key=KEY_MAX held; -edge-> INIT_GO with key=0
//  Done inputs sampled only in the matching *_RUN state; done in GO states or other phases ignored.
//  Bad byte: dec_aWren=1 and dec_aIn not in 8'h61..8'h7A and not 8'h20.
//  Simultaneous bad byte and dec_done in same cycle: treated as bad (abort path).
//  Arbitration (combinational on state): INIT_* -> init port; SHUF_* -> shuf port; DEC_* -> dec port;
//   all other states sAddr=0, sIn=0, sWren=0. Non-selected phases' sWren never reaches RAM.
//  Phase-to-phase gap: done sampled at edge t, next *_start high in cycle t+1, owner switches at t+1.
//  key increments only in NEXT_KEY; width KEY_WIDTH, never wraps (KEY_MAX guards).
//  reset_n low mid-search: immediate return to reset values; no pulse outputs glitch high.
// TESTING
//  Reset mid-SHUF_RUN (key=5) -> all outputs at reset values; next start edge starts key=0.
//  Stub phases done 3 cycles after start; dec writes 32 bytes 8'h61 -> found=1, key=0, busy=0; each *_start exactly 1 cycle.
//  dec writes 8'h07 at key 0..2, valid text at key 3 -> 3 phase_abort pulses, found=1, key=3.
//  KEY_MAX=3, always bad bytes -> fail=1, key=3, no FOUND; 4 init_start pulses total.
//  Drive init_sWren=1 during DEC_RUN and dec_done during INIT_GO -> sWren follows dec port only; done ignored.
//  start held high 100 cycles after FOUND -> no relaunch until start falls and rises again.

Source files
------------

// File: rtl/rc4_phase_sequencer_if.sv
// Connection bundle between the RC4 phase sequencer and its three S-memory phase engines.
// The bundle also carries the arbitrated S RAM port.
interface rc4_phase_sequencer_if #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_LENGTH = 8,
    parameter int KEY_WIDTH  = 24
);
    logic                  start;
    logic [KEY_WIDTH-1:0]  key;

    logic                  init_start;
    logic                  init_done;
    logic [RAM_LENGTH-1:0] init_sAddr;
    logic [RAM_WIDTH-1:0]  init_sIn;
    logic                  init_sWren;

    logic                  shuf_start;
    logic                  shuf_done;
    logic [RAM_LENGTH-1:0] shuf_sAddr;
    logic [RAM_WIDTH-1:0]  shuf_sIn;
    logic                  shuf_sWren;

    logic                  dec_start;
    logic                  dec_done;
    logic [RAM_LENGTH-1:0] dec_sAddr;
    logic [RAM_WIDTH-1:0]  dec_sIn;
    logic                  dec_sWren;
    logic [RAM_WIDTH-1:0]  dec_aIn;
    logic                  dec_aWren;
    logic                  phase_abort;

    logic [RAM_LENGTH-1:0] sAddr;
    logic [RAM_WIDTH-1:0]  sIn;
    logic                  sWren;

    logic                  busy;
    logic                  found;
    logic                  fail;

    modport master (
        input  start,
        input  init_done, init_sAddr, init_sIn, init_sWren,
        input  shuf_done, shuf_sAddr, shuf_sIn, shuf_sWren,
        input  dec_done, dec_sAddr, dec_sIn, dec_sWren, dec_aIn, dec_aWren,
        output key, init_start, shuf_start, dec_start, phase_abort,
        output sAddr, sIn, sWren, busy, found, fail
    );

    modport slave (
        output start,
        output init_done, init_sAddr, init_sIn, init_sWren,
        output shuf_done, shuf_sAddr, shuf_sIn, shuf_sWren,
        output dec_done, dec_sAddr, dec_sIn, dec_sWren, dec_aIn, dec_aWren,
        input  key, init_start, shuf_start, dec_start, phase_abort,
        input  sAddr, sIn, sWren, busy, found, fail
    );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// RC4 key-search scheduler: runs init/shuffle/decrypt per candidate key, owns the S RAM mux,
// and steps the key until the decrypted text is printable or the key range is exhausted.
module rc4_phase_sequencer #(
    parameter int          RAM_WIDTH  = 8,
    parameter int          RAM_LENGTH = 8,
    parameter int          KEY_WIDTH  = 24,
    parameter int unsigned KEY_MAX    = 2**22 - 1
) (
    input logic                   clk,
    input logic                   reset_n,
    rc4_phase_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_GO, S_INIT_RUN, S_SHUF_GO, S_SHUF_RUN,
        S_DEC_GO, S_DEC_RUN, S_NEXT_KEY, S_FOUND, S_EXHAUSTED
    } state_t;

    localparam logic [RAM_WIDTH-1:0] CHAR_LO  = RAM_WIDTH'(8'h61);
    localparam logic [RAM_WIDTH-1:0] CHAR_HI  = RAM_WIDTH'(8'h7A);
    localparam logic [RAM_WIDTH-1:0] CHAR_SP  = RAM_WIDTH'(8'h20);
    localparam logic [KEY_WIDTH-1:0] KEY_LAST = KEY_WIDTH'(KEY_MAX);

    state_t                state, state_next;
    logic                  start_q, start_edge, at_rest, rest_next;
    logic                  bad_q, bad_byte, abort_now;
    logic [KEY_WIDTH-1:0]  key_q;
    logic                  init_start_q, shuf_start_q, dec_start_q, phase_abort_q;
    logic                  busy_q, found_q, fail_q;
    logic [RAM_LENGTH-1:0] s_addr;
    logic [RAM_WIDTH-1:0]  s_in;
    logic                  s_wren;

    assign start_edge = bus.start & ~start_q;
    assign at_rest    = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED);
    assign rest_next  = state_next inside {S_IDLE, S_FOUND, S_EXHAUSTED};
    assign bad_byte   = bus.dec_aWren &&
                        !(((bus.dec_aIn >= CHAR_LO) && (bus.dec_aIn <= CHAR_HI)) || (bus.dec_aIn == CHAR_SP));
    // A bad byte arriving together with dec_done still takes the abort path.
    assign abort_now  = (state == S_DEC_RUN) && (bad_byte || bad_q);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED: if (start_edge) state_next = S_INIT_GO;
            S_INIT_GO:  state_next = S_INIT_RUN;
            S_INIT_RUN: if (bus.init_done) state_next = S_SHUF_GO;
            S_SHUF_GO:  state_next = S_SHUF_RUN;
            S_SHUF_RUN: if (bus.shuf_done) state_next = S_DEC_GO;
            S_DEC_GO:   state_next = S_DEC_RUN;
            S_DEC_RUN: begin
                if (abort_now)         state_next = (key_q == KEY_LAST) ? S_EXHAUSTED : S_NEXT_KEY;
                else if (bus.dec_done) state_next = S_FOUND;
            end
            S_NEXT_KEY: state_next = S_INIT_GO;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_addr = '0;
        s_in   = '0;
        s_wren = 1'b0;
        case (state)
            S_INIT_GO, S_INIT_RUN: begin
                s_addr = bus.init_sAddr; s_in = bus.init_sIn; s_wren = bus.init_sWren;
            end
            S_SHUF_GO, S_SHUF_RUN: begin
                s_addr = bus.shuf_sAddr; s_in = bus.shuf_sIn; s_wren = bus.shuf_sWren;
            end
            S_DEC_GO, S_DEC_RUN: begin
                s_addr = bus.dec_sAddr;  s_in = bus.dec_sIn;  s_wren = bus.dec_sWren;
            end
            default: ;
        endcase
    end

    // Status and pulse outputs are registered from the next state so they come straight off flops.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            start_q       <= 1'b0;
            key_q         <= '0;
            bad_q         <= 1'b0;
            init_start_q  <= 1'b0;
            shuf_start_q  <= 1'b0;
            dec_start_q   <= 1'b0;
            phase_abort_q <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= bus.start;
            if (at_rest && start_edge)    key_q <= '0;
            else if (state == S_NEXT_KEY) key_q <= key_q + KEY_WIDTH'(1);
            if (state == S_DEC_GO)                    bad_q <= 1'b0;
            else if ((state == S_DEC_RUN) && bad_byte) bad_q <= 1'b1;
            init_start_q  <= (state_next == S_INIT_GO);
            shuf_start_q  <= (state_next == S_SHUF_GO);
            dec_start_q   <= (state_next == S_DEC_GO);
            phase_abort_q <= abort_now;
            busy_q        <= !rest_next;
            found_q       <= (state_next == S_FOUND);
            fail_q        <= (state_next == S_EXHAUSTED);
        end
    end

    assign bus.key         = key_q;
    assign bus.init_start  = init_start_q;
    assign bus.shuf_start  = shuf_start_q;
    assign bus.dec_start   = dec_start_q;
    assign bus.phase_abort = phase_abort_q;
    assign bus.sAddr       = s_addr;
    assign bus.sIn         = s_in;
    assign bus.sWren       = s_wren;
    assign bus.busy        = busy_q;
    assign bus.found       = found_q;
    assign bus.fail        = fail_q;

endmodule
